// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared definitions for the instruction-fetch / load-store memory
//            arbiter. It holds the memory access-mode encoding, the arbiter
//            FSM state encoding and the grant identifiers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Memory access-mode encoding carried on ls_mode / mem_mode
    localparam logic [2:0] c_MODE_BYTE   = 3'b000;
    localparam logic [2:0] c_MODE_HALF   = 3'b001;
    localparam logic [2:0] c_MODE_WORD   = 3'b010;
    localparam logic [2:0] c_MODE_BYTE_U = 3'b011;
    localparam logic [2:0] c_MODE_HALF_U = 3'b100;
    localparam logic [2:0] c_MODE_NONE   = 3'b111;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Grant identifiers, used both for the current grant and for last_grant
    localparam logic c_GRANT_LS = 1'b0;
    localparam logic c_GRANT_IF = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates one shared memory port between an instruction-fetch
//            requester and a load/store requester. Round-robin on ties, one
//            transaction at a time, with a watchdog that completes a stalled
//            access with an error after TIMEOUT cycles.
// Ports    : clk, rst                     - clock, synchronous active-high reset
//            if_req/if_addr               - fetch request (held until if_ack)
//            if_rdata/if_ack/if_err       - fetch response
//            ls_req/ls_we/ls_addr/
//            ls_wdata/ls_mode             - load/store request (held until ls_ack)
//            ls_rdata/ls_ack/ls_err       - load/store response
//            mem_req/mem_we/mem_addr/
//            mem_wdata/mem_mode           - registered shared memory request
//            mem_rdata/mem_ack            - memory response
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64      // 2..255 BUSY cycles before giving up
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [2:0]  ls_mode,
    output logic [31:0] ls_rdata,
    output logic        ls_ack,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_mode,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // Value of the BUSY counter during the last permitted BUSY cycle
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_t  r_state;
    logic        r_last_grant;
    logic        r_grant;
    logic [7:0]  r_cnt;
    logic        r_timed_out;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [2:0]  r_mem_mode;
    logic [31:0] r_if_rdata;
    logic [31:0] r_ls_rdata;

    arb_state_t  w_state_next;
    logic        w_do_grant;
    logic        w_grant_if;
    logic        w_timeout;

    // ------------------------------------------------------------------
    // Next-state logic and arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_do_grant   = 1'b0;
        w_grant_if   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    w_do_grant   = 1'b1;
                    // On a tie the requester that was not served last wins
                    w_grant_if   = if_req && (!ls_req || (r_last_grant == c_GRANT_LS));
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // mem_ack takes priority over an expiring watchdog
                if (mem_ack) begin
                    w_state_next = ST_RESP;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                // Requests are ignored here so requesters can drop req
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register, request registers, watchdog and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= c_GRANT_IF;
            r_grant      <= c_GRANT_LS;
            r_cnt        <= 8'd0;
            r_timed_out  <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_mode   <= c_MODE_NONE;
            r_if_rdata   <= 32'd0;
            r_ls_rdata   <= 32'd0;
        end else begin
            r_state   <= w_state_next;
            r_mem_req <= (w_state_next == ST_BUSY);

            if (w_do_grant) begin
                r_grant      <= w_grant_if;
                r_last_grant <= w_grant_if;
                r_cnt        <= 8'd0;
                r_timed_out  <= 1'b0;
                if (w_grant_if) begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= if_addr;
                    r_mem_wdata <= 32'd0;
                    r_mem_mode  <= c_MODE_WORD;
                end else begin
                    r_mem_we    <= ls_we;
                    r_mem_addr  <= ls_addr;
                    r_mem_wdata <= ls_wdata;
                    r_mem_mode  <= ls_mode;
                end
            end

            if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + 8'd1;
                if (mem_ack) begin
                    if (r_grant == c_GRANT_IF) begin
                        r_if_rdata <= mem_rdata;
                    end else if (!r_mem_we) begin
                        r_ls_rdata <= mem_rdata;
                    end
                end else if (w_timeout) begin
                    r_timed_out <= 1'b1;
                    // A timed-out write still leaves ls_rdata untouched
                    if (r_grant == c_GRANT_IF) begin
                        r_if_rdata <= 32'd0;
                    end else if (!r_mem_we) begin
                        r_ls_rdata <= 32'd0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode: ack/err pulse only in RESP for the granted requester
    // ------------------------------------------------------------------
    always_comb begin
        if_ack = 1'b0;
        if_err = 1'b0;
        ls_ack = 1'b0;
        ls_err = 1'b0;
        if (r_state == ST_RESP) begin
            if (r_grant == c_GRANT_IF) begin
                if_ack = 1'b1;
                if_err = r_timed_out;
            end else begin
                ls_ack = 1'b1;
                ls_err = r_timed_out;
            end
        end
    end

    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_mode  = r_mem_mode;

endmodule
`default_nettype wire
